// File: rtl/wb_bram_ctrl.sv
// Wishbone slave front end for the 32-bit user-project BRAM: window decode, programmable wait states, one byte-enabled access per transfer.
// Optional build macro WB_BRAM_RDREG_EN registers read data in an extra RDREG state (read latency DELAY+2).
module wb_bram_ctrl #(
  parameter int unsigned DELAY     = 10,
  parameter logic [31:0] ADDR_BASE = 32'h3800_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFC0_0000,
  parameter int unsigned BRAM_AW   = 10
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        bram_en,
  output logic [3:0]  bram_we,
  output logic [31:0] bram_a,
  output logic [31:0] bram_di,
  input  logic [31:0] bram_do
);

  localparam int CW = $clog2(DELAY + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DELAY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RDREG, S_ACK} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic                we_q;
  logic [3:0]          sel_q;
  logic [BRAM_AW-1:0]  adr_q;
  logic [31:0]         dat_q;
  logic                hit;
  logic                issue;

  assign hit   = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == ADDR_BASE);
  // The access slot is dropped if the master abandons the cycle in it.
  assign issue = (state == S_WAIT) && (cnt == '0) && wbs_cyc_i;

`ifdef WB_BRAM_RDREG_EN
  logic [31:0] rd_q;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= S_IDLE;
      cnt   <= '0;
      we_q  <= 1'b0;
      sel_q <= 4'h0;
      adr_q <= '0;
      dat_q <= '0;
`ifdef WB_BRAM_RDREG_EN
      rd_q  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (hit) begin
            state <= S_WAIT;
            cnt   <= CNT_LOAD;
            we_q  <= wbs_we_i;
            sel_q <= wbs_sel_i;
            adr_q <= wbs_adr_i[BRAM_AW+1:2];
            dat_q <= wbs_dat_i;
          end
        end
        S_WAIT: begin
          if (!wbs_cyc_i) begin
            state <= S_IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
`ifdef WB_BRAM_RDREG_EN
            state <= we_q ? S_ACK : S_RDREG;
`else
            state <= S_ACK;
`endif
          end
        end
`ifdef WB_BRAM_RDREG_EN
        S_RDREG: begin
          if (!wbs_cyc_i) begin
            state <= S_IDLE;
          end else begin
            rd_q  <= bram_do;
            state <= S_ACK;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  assign wbs_ack_o = (state == S_ACK);
`ifdef WB_BRAM_RDREG_EN
  assign wbs_dat_o = (state == S_ACK && !we_q) ? rd_q : 32'h0;
`else
  assign wbs_dat_o = (state == S_ACK && !we_q) ? bram_do : 32'h0;
`endif

  assign bram_en = issue;
  assign bram_we = (issue && we_q) ? sel_q : 4'h0;
  assign bram_a  = {{(32 - BRAM_AW){1'b0}}, adr_q};
  assign bram_di = dat_q;

endmodule

// File: tb/tb_wb_bram_ctrl.sv
// Bench for wb_bram_ctrl: a DELAY=10 and a DELAY=1 instance, each with its own BRAM model, checked against a word-array reference.
module tb_wb_bram_ctrl;

`ifdef WB_BRAM_RDREG_EN
  localparam bit RDREG = 1'b1;
`else
  localparam bit RDREG = 1'b0;
`endif

  typedef struct {
    bit          got;
    int          lat;
    int          en_cnt;
    int          en_n;
    logic [3:0]  we;
    logic [31:0] a;
    logic [31:0] di;
    logic [31:0] rd;
    bit          leak;
  } obs_t;

  logic clk = 1'b0;
  logic rst, load;
  logic cyc, stb, we;
  logic [3:0] sel;
  logic [31:0] adr, dat;
  bit which;

  logic cyc0, cyc1;
  logic ack0, ack1, en0, en1;
  logic [3:0] bwe0, bwe1;
  logic [31:0] dato0, dato1, ba0, ba1, bdi0, bdi1, bdo0, bdo1;
  logic ack, bram_en;
  logic [3:0] bram_we;
  logic [31:0] dat_o, bram_a, bram_di;

  logic [31:0] mem0 [1024];
  logic [31:0] mem1 [1024];
  logic [31:0] exp_mem [2][1024];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign cyc0 = cyc & ~which;
  assign cyc1 = cyc & which;
  assign ack     = which ? ack1  : ack0;
  assign dat_o   = which ? dato1 : dato0;
  assign bram_en = which ? en1   : en0;
  assign bram_we = which ? bwe1  : bwe0;
  assign bram_a  = which ? ba1   : ba0;
  assign bram_di = which ? bdi1  : bdi0;

  wb_bram_ctrl #(.DELAY(10)) u_dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc0), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack0), .wbs_dat_o(dato0),
    .bram_en(en0), .bram_we(bwe0), .bram_a(ba0), .bram_di(bdi0), .bram_do(bdo0));

  wb_bram_ctrl #(.DELAY(1)) u_dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc1), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack1), .wbs_dat_o(dato1),
    .bram_en(en1), .bram_we(bwe1), .bram_a(ba1), .bram_di(bdi1), .bram_do(bdo1));

  function automatic logic [31:0] init_word(bit wh, int i);
    return (32'(i) * 32'h9E37_79B1) ^ (wh ? 32'h1234_5678 : 32'hA5A5_0F0F);
  endfunction

  // Synchronous-read BRAM with per-byte write enables and zero output when idle
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 1024; i++) begin
        mem0[i] <= init_word(1'b0, i);
        mem1[i] <= init_word(1'b1, i);
      end
      bdo0 <= '0;
      bdo1 <= '0;
    end else begin
      if (en0) begin
        bdo0 <= mem0[ba0[9:0]];
        for (int b = 0; b < 4; b++) if (bwe0[b]) mem0[ba0[9:0]][8*b +: 8] <= bdi0[8*b +: 8];
      end else bdo0 <= '0;
      if (en1) begin
        bdo1 <= mem1[ba1[9:0]];
        for (int b = 0; b < 4; b++) if (bwe1[b]) mem1[ba1[9:0]][8*b +: 8] <= bdi1[8*b +: 8];
      end else bdo1 <= '0;
    end
  end

  function automatic int exp_lat(bit wh, bit w, bit b2b);
    return (wh ? 1 : 10) + 1 + (b2b ? 1 : 0) + ((RDREG && !w) ? 1 : 0);
  endfunction

  task automatic model_write(input bit wh, input logic [9:0] wd, input logic [3:0] s, input logic [31:0] d);
    for (int b = 0; b < 4; b++) if (s[b]) exp_mem[wh][wd][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic idle();
    @(negedge clk);
    cyc = 0; stb = 0; we = 0; sel = 4'h0; adr = 32'h0; dat = 32'h0;
  endtask

  task automatic xfer(input bit w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d, output obs_t o);
    o.got = 0; o.lat = 0; o.en_cnt = 0; o.en_n = 0; o.we = 4'h0;
    o.a = 32'h0; o.di = 32'h0; o.rd = 32'h0; o.leak = 0;
    @(negedge clk);
    cyc = 1; stb = 1; we = w; sel = s; adr = a; dat = d;
    while (!o.got && o.lat < 64) begin
      @(posedge clk); #1;
      o.lat++;
      if (bram_en) begin
        o.en_cnt++; o.en_n = o.lat; o.we = bram_we; o.a = bram_a; o.di = bram_di;
      end
      if (ack) begin
        o.got = 1; o.rd = dat_o;
      end else if (dat_o !== 32'h0) o.leak = 1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] pre_a;
    obs_t o;
    bit bad;
    which = 0;
    checks++;
    if (ack0 !== 0 || ack1 !== 0 || dato0 !== 0 || en0 !== 0 || bwe0 !== 0 || ba0 !== 0 || bdi0 !== 0)
      begin errors++; $display("FAIL reset_state ack=%b dat=%h en=%b we=%h a=%h di=%h required all 0", ack0, dato0, en0, bwe0, ba0, bdi0); end
    @(negedge clk) rst = 0;
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; sel = 4'hF; adr = 32'h3800_0020; dat = $urandom;
    repeat (4) @(posedge clk);
    #3 pre_a = bram_a;
    rst = 1;
    #1;
    checks++;
    if (pre_a !== 32'd8 || ack !== 0 || dat_o !== 0 || bram_en !== 0 || bram_we !== 0 || bram_a !== 0 || bram_di !== 0)
      begin errors++; $display("FAIL reset_async pre_a=%h a=%h di=%h ack=%b en=%b required pre_a=8 and all 0", pre_a, bram_a, bram_di, ack, bram_en); end
    cyc = 0; stb = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;
    bad = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (ack || bram_en) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL reset_release activity=%b required 0", bad); end
    xfer(0, 4'hF, 32'h3800_0020, 32'h0, o);
    idle();
    checks++;
    if (!o.got || o.rd !== exp_mem[0][8])
      begin errors++; $display("FAIL reset_dropped_write got=%b rd=%h required %h", o.got, o.rd, exp_mem[0][8]); end
  endtask

  task automatic test_write_full();
    obs_t o;
    which = 0;
    xfer(1, 4'hF, 32'h3800_0010, 32'hDEAD_BEEF, o);
    idle();
    checks++;
    if (!o.got || o.lat != 11) begin errors++; $display("FAIL write_latency got=%b lat=%0d required 11", o.got, o.lat); end
    checks++;
    if (o.en_cnt != 1 || o.we !== 4'hF || o.a !== 32'd4 || o.di !== 32'hDEAD_BEEF || o.lat - o.en_n != 1)
      begin errors++; $display("FAIL write_port en_cnt=%0d we=%h a=%h di=%h en_n=%0d required 1 F 4 DEADBEEF 10", o.en_cnt, o.we, o.a, o.di, o.en_n); end
    checks++;
    if (o.rd !== 32'h0 || o.leak) begin errors++; $display("FAIL write_dat_o rd=%h leak=%b required 0", o.rd, o.leak); end
    model_write(0, 10'd4, 4'hF, 32'hDEAD_BEEF);
  endtask

  task automatic test_partial_read();
    obs_t o;
    which = 0;
    xfer(1, 4'b0010, 32'h3800_0010, 32'h0000_AB00, o);
    idle();
    checks++;
    if (o.en_cnt != 1 || o.we !== 4'b0010) begin errors++; $display("FAIL partial_we en_cnt=%0d we=%h required 1 2", o.en_cnt, o.we); end
    model_write(0, 10'd4, 4'b0010, 32'h0000_AB00);
    xfer(0, 4'hF, 32'h3800_0010, 32'h0, o);
    idle();
    checks++;
    if (!o.got || o.rd !== 32'hDEAD_ABEF || o.rd !== exp_mem[0][4] || o.leak || o.lat != exp_lat(0, 0, 0))
      begin errors++; $display("FAIL partial_read got=%b rd=%h leak=%b lat=%0d required DEADABEF", o.got, o.rd, o.leak, o.lat); end
    @(posedge clk); #1;
    checks++;
    if (dat_o !== 32'h0 || ack !== 0) begin errors++; $display("FAIL read_after dat_o=%h ack=%b required 0 0", dat_o, ack); end
  endtask

  task automatic test_miss_and_wrap();
    obs_t o;
    bit bad;
    which = 0;
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; sel = 4'hF; adr = 32'h3000_0000; dat = 32'h1111_2222;
    bad = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (ack || bram_en) bad = 1;
    end
    idle();
    checks++;
    if (bad) begin errors++; $display("FAIL miss_ignored activity=%b required 0", bad); end
    xfer(0, 4'hF, 32'h3800_1010, 32'h0, o);
    idle();
    checks++;
    if (!o.got || o.a !== 32'd4 || o.rd !== exp_mem[0][4])
      begin errors++; $display("FAIL wrap got=%b a=%h rd=%h required 4 %h", o.got, o.a, o.rd, exp_mem[0][4]); end
  endtask

  task automatic test_abort();
    obs_t o;
    bit bad;
    which = 0;
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; sel = 4'hF; adr = 32'h3800_001C; dat = $urandom;
    bad = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bram_en || ack) bad = 1;
    end
    @(negedge clk) cyc = 0; stb = 0;
    @(posedge clk); #1;
    if (bram_en || ack) bad = 1;
    checks++;
    if (bad) begin errors++; $display("FAIL abort_wait activity=%b required 0", bad); end
    xfer(0, 4'hF, 32'h3800_001C, 32'h0, o);
    idle();
    checks++;
    if (!o.got || o.lat != exp_lat(0, 0, 0) || o.rd !== exp_mem[0][7])
      begin errors++; $display("FAIL abort_readback lat=%0d rd=%h required %0d %h", o.lat, o.rd, exp_lat(0, 0, 0), exp_mem[0][7]); end
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; sel = 4'hF; adr = 32'h3800_0024; dat = $urandom;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (bram_en !== 1) begin errors++; $display("FAIL abort_slot_pre en=%b required 1", bram_en); end
    cyc = 0; stb = 0;
    #1;
    checks++;
    if (bram_en !== 0 || bram_we !== 4'h0) begin errors++; $display("FAIL abort_slot en=%b we=%h required 0 0", bram_en, bram_we); end
    bad = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ack || bram_en) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL abort_slot_ack activity=%b required 0", bad); end
    xfer(0, 4'hF, 32'h3800_0024, 32'h0, o);
    idle();
    checks++;
    if (!o.got || o.rd !== exp_mem[0][9])
      begin errors++; $display("FAIL abort_slot_readback rd=%h required %h", o.rd, exp_mem[0][9]); end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    which = 1;
    for (int i = 0; i < 4; i++) begin
      xfer(0, 4'hF, 32'h3800_0000 + 32'(4 * i), $urandom, o);
      checks++;
      if (!o.got || o.lat != exp_lat(1, 0, i > 0) || o.rd !== exp_mem[1][i] || o.en_cnt != 1)
        begin errors++; $display("FAIL b2b_read%0d lat=%0d rd=%h en_cnt=%0d required %0d %h 1", i, o.lat, o.rd, o.en_cnt, exp_lat(1, 0, i > 0), exp_mem[1][i]); end
    end
    idle();
  endtask

  task automatic test_random();
    obs_t o;
    bit open, wh, w, b2b;
    logic [3:0] s;
    logic [31:0] a, d, expd;
    logic [9:0] wd;
    open = 0;
    for (int i = 0; i < 40; i++) begin
      wh = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      s  = 4'($urandom);
      a  = 32'h3800_0000 | ($urandom & 32'h003F_FFFF);
      d  = $urandom;
      b2b = open && (wh == which) && ($urandom_range(0, 1) == 1);
      if (open && !b2b) idle();
      which = wh;
      wd = a[11:2];
      expd = w ? 32'h0 : exp_mem[wh][wd];
      xfer(w, s, a, d, o);
      checks++;
      if (!o.got || o.lat != exp_lat(wh, w, b2b))
        begin errors++; $display("FAIL rnd%0d_latency dut=%0d got=%b lat=%0d required %0d", i, wh, o.got, o.lat, exp_lat(wh, w, b2b)); end
      checks++;
      if (o.en_cnt != 1 || o.we !== (w ? s : 4'h0) || o.a !== {22'h0, wd} || o.di !== d)
        begin errors++; $display("FAIL rnd%0d_port en_cnt=%0d we=%h a=%h di=%h required 1 %h %h %h", i, o.en_cnt, o.we, o.a, o.di, (w ? s : 4'h0), {22'h0, wd}, d); end
      checks++;
      if (o.rd !== expd || o.leak)
        begin errors++; $display("FAIL rnd%0d_data rd=%h leak=%b required %h", i, o.rd, o.leak, expd); end
      if (w) model_write(wh, wd, s, d);
      open = 1;
    end
    idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; load = 1; which = 0;
    cyc = 0; stb = 0; we = 0; sel = 4'h0; adr = 32'h0; dat = 32'h0;
    for (int i = 0; i < 1024; i++) begin
      exp_mem[0][i] = init_word(1'b0, i);
      exp_mem[1][i] = init_word(1'b1, i);
    end
    @(posedge clk); #1 load = 0;
    test_reset();
    test_write_full();
    test_partial_read();
    test_miss_and_wrap();
    test_abort();
    test_back_to_back();
    test_random();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_bram_ctrl.md
# wb_bram_ctrl

Wishbone-slave front end for the user-project 32-bit block RAM. It decodes a fixed address window on the Caravel Wishbone bus and inserts a programmable number of wait states. It then drives one byte-enabled access on the BRAM port (synchronous read, per-byte write enable, zero output when not enabled) and returns a single-cycle ack with read data. It sits directly upstream of the BRAM instance in the user project.

## Interface
- DELAY, 10: wait states between request acceptance and BRAM access; legal range 1..255.
- ADDR_BASE, 32'h3800_0000: window base address.
- ADDR_MASK, 32'hFFC0_0000: bits compared against ADDR_BASE for a hit.
- BRAM_AW, 10: BRAM word-address width (1024 words).

Ports:
- wb_clk_i  in  1  single clock; all logic on rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- wbs_cyc_i  in  1  bus cycle valid.
- wbs_stb_i  in  1  strobe.
- wbs_we_i  in  1  1 = write.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  transfer acknowledge.
- wbs_dat_o  out  32  read data.
- bram_en  out  1  BRAM enable.
- bram_we  out  4  BRAM byte write enables.
- bram_a  out  32  BRAM word index, zero-extended from BRAM_AW bits.
- bram_di  out  32  BRAM write data.
- bram_do  in  32  BRAM read data; valid the cycle after an enabled edge, 0 otherwise.

## Operation
- Hit = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == ADDR_BASE). A non-hit is ignored, with no ack.
- FSM states are IDLE, WAIT, ACK.
- IDLE -> WAIT on hit. The transition latches we, sel, dat_i, and word index = wbs_adr_i[BRAM_AW+1:2]. Higher in-window bits alias (wrap) onto BRAM. The counter loads DELAY-1.
- WAIT: counter decrements each cycle while >0.
  - When the counter is 0: bram_en=1, bram_we = latched_we ? latched_sel : 4'h0, and the next state is ACK.
  - bram_en and bram_we are decoded combinationally from the state and counter; they are high for exactly one cycle per transfer.
- ACK: wbs_ack_o=1 for exactly one cycle, and the next state is IDLE.
  - For reads, wbs_dat_o = bram_do during ACK.
  - wbs_dat_o is 0 in every other state and for writes.
- Abort: if wbs_cyc_i is low in WAIT or ACK, go to IDLE immediately, with no ack.
  - If the abort falls in the counter==0 cycle, bram_en/bram_we are suppressed.
  - A write already issued is not undone.
- bram_a and bram_di hold the latched values until the next accepted request.
- A request seen in ACK is not accepted; it is evaluated again in IDLE. The Wishbone master drops stb after sampling ack.
- Counter width is $clog2(DELAY+1). Arithmetic is unsigned with no underflow; the decrement is gated at 0.

## Timing
- Reset (async assert, sync release): state=IDLE, counter=0, latches=0, wbs_ack_o=0, wbs_dat_o=0, bram_en=0, bram_we=0, bram_a=0, bram_di=0.
- Edge E0 accepts the hit. bram_en is high in the cycle after E(DELAY-1), the BRAM samples at E(DELAY), and ack is high in the cycle after E(DELAY).
- Request-to-ack latency = DELAY+1 cycles (11 at default); back-to-back throughput is one transfer per DELAY+2 cycles.
- Reset asserted mid-transfer: outputs clear immediately, no ack, and any BRAM access not yet issued is dropped.

## Configuration
- WB_BRAM_RDREG_EN defined: a register is inserted on read data. An extra state RDREG between WAIT and ACK captures bram_do. ack asserts one cycle later (latency DELAY+2), and wbs_dat_o is driven from the register. Write latency is unchanged (DELAY+1).
- Undefined: read data passes combinationally from bram_do during ACK, as described above.

## Test plan
- Reset: assert wb_rst_i mid-cycle without a clock edge -> all outputs 0 immediately; after release, FSM idle, no ack.
- Write 32'hDEADBEEF, sel 4'hF, to 0x3800_0010, DELAY=10:
  - bram_en/bram_we=4'hF are high for one cycle with bram_a=4 and bram_di=32'hDEADBEEF.
  - ack is high exactly 11 cycles after acceptance.
- Partial write sel 4'b0010 of 32'h0000AB00 to word 4, then read 0x3800_0010 -> wbs_dat_o=32'hDEADABEF in the ack cycle, and 0 before and after.
- Address 0x3000_0000 with cyc/stb held 30 cycles -> no ack, bram_en never asserted. Address 0x3800_1010 -> wraps to bram_a=4.
- Abort: drop wbs_cyc_i 3 cycles into WAIT on a write -> no bram_we pulse, no ack, FSM in IDLE next cycle; the following read returns the old contents.
- DELAY=1, back-to-back reads of words 0..3 -> each ack 2 cycles after acceptance, data matches preload. With WB_BRAM_RDREG_EN, each ack is 3 cycles after acceptance.
